// File: rtl/hazard_ctrl_if.sv
// Decode-side control in, hazard controls and perf counters out, between the
// 5-stage core (master) and the hazard controller (slave).
interface hazard_ctrl_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 32
);
  logic                  i_valid_d;
  logic [ADDR_WIDTH-1:0] i_rs1_addr_d;
  logic [ADDR_WIDTH-1:0] i_rs2_addr_d;
  logic [ADDR_WIDTH-1:0] i_rd_addr_d;
  logic                  i_regwrite_d;
  logic [1:0]            i_resultsrc_d;
  logic                  i_pcsrc_e;

  logic                  o_stall_f;
  logic                  o_stall_d;
  logic                  o_flush_d;
  logic                  o_flush_e;
  logic [1:0]            o_forward_a_e;
  logic [1:0]            o_forward_b_e;
  logic [CNT_WIDTH-1:0]  o_stall_cnt;
  logic [CNT_WIDTH-1:0]  o_flush_cnt;

  modport master (
    output i_valid_d, i_rs1_addr_d, i_rs2_addr_d, i_rd_addr_d,
           i_regwrite_d, i_resultsrc_d, i_pcsrc_e,
    input  o_stall_f, o_stall_d, o_flush_d, o_flush_e,
           o_forward_a_e, o_forward_b_e, o_stall_cnt, o_flush_cnt
  );

  modport slave (
    input  i_valid_d, i_rs1_addr_d, i_rs2_addr_d, i_rd_addr_d,
           i_regwrite_d, i_resultsrc_d, i_pcsrc_e,
    output o_stall_f, o_stall_d, o_flush_d, o_flush_e,
           o_forward_a_e, o_forward_b_e, o_stall_cnt, o_flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller: shadows the EX/MEM/WB occupants to derive load-use stalls,
// branch flushes and EX forwarding selects, plus saturating stall/flush counters.
module hazard_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 32
) (
  input logic         i_clk,
  input logic         i_rst,
  hazard_ctrl_if.slave hz
);

  typedef struct packed {
    logic                  v;
    logic [ADDR_WIDTH-1:0] rs1;
    logic [ADDR_WIDTH-1:0] rs2;
    logic [ADDR_WIDTH-1:0] rd;
    logic                  regwrite;
    logic                  load;
  } ex_slot_t;

  typedef struct packed {
    logic                  v;
    logic [ADDR_WIDTH-1:0] rd;
    logic                  regwrite;
  } wr_slot_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  ex_slot_t             ex_q, ex_d;
  wr_slot_t             mem_q, mem_d;
  wr_slot_t             wb_q, wb_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  logic lu_hazard;
  logic stall;
  logic flush_e;

  // x0 is never a forwarding source; MEM wins over WB when both hold the register.
  function automatic logic [1:0] fwd_sel(input logic                  ex_v,
                                         input logic [ADDR_WIDTH-1:0] src,
                                         input wr_slot_t              mem,
                                         input wr_slot_t              wb);
    logic [1:0] sel;
    sel = FWD_RF;
    if (ex_v) begin
      if (mem.v && mem.regwrite && (mem.rd != '0) && (mem.rd == src))
        sel = FWD_MEM;
      else if (wb.v && wb.regwrite && (wb.rd != '0) && (wb.rd == src))
        sel = FWD_WB;
    end
    return sel;
  endfunction

  // A taken branch overrides the load-use stall: the dependent instruction is wrong-path.
  always_comb begin
    lu_hazard = ex_q.v && ex_q.load && (ex_q.rd != '0) && hz.i_valid_d &&
                ((ex_q.rd == hz.i_rs1_addr_d) || (ex_q.rd == hz.i_rs2_addr_d));
    stall     = lu_hazard && !hz.i_pcsrc_e;
    flush_e   = hz.i_pcsrc_e || lu_hazard;
  end

  assign hz.o_stall_f     = stall;
  assign hz.o_stall_d     = stall;
  assign hz.o_flush_d     = hz.i_pcsrc_e;
  assign hz.o_flush_e     = flush_e;
  assign hz.o_forward_a_e = fwd_sel(ex_q.v, ex_q.rs1, mem_q, wb_q);
  assign hz.o_forward_b_e = fwd_sel(ex_q.v, ex_q.rs2, mem_q, wb_q);
  assign hz.o_stall_cnt   = stall_cnt_q;
  assign hz.o_flush_cnt   = flush_cnt_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wb_d  = mem_q;
    mem_d = '{v: ex_q.v, rd: ex_q.rd, regwrite: ex_q.regwrite};
    ex_d  = '0;
    if (!flush_e) begin
      ex_d = '{v:        hz.i_valid_d,
               rs1:      hz.i_rs1_addr_d,
               rs2:      hz.i_rs2_addr_d,
               rd:       hz.i_rd_addr_d,
               regwrite: hz.i_regwrite_d,
               load:     (hz.i_resultsrc_d == 2'b01)};
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;

    flush_cnt_d = flush_cnt_q;
    if (hz.i_pcsrc_e && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all slots advance from pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a pipeline-occupancy model checked every cycle,
// plus hand-computed expectations for each hazard scenario.
module tb_hazard_ctrl;

  localparam int AW   = 5;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) hz ();

  hazard_ctrl #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .hz    (hz)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: who occupies EX (0), MEM (1), WB (2)
  typedef struct {
    bit v;
    int rs1;
    int rs2;
    int rd;
    bit rw;
    bit ld;
  } occ_t;

  occ_t pipe [3];
  int   m_stall = 0;
  int   m_flush = 0;
  bit   model_ok = 1'b0;

  function automatic occ_t empty_occ();
    occ_t o;
    o.v = 0; o.rs1 = 0; o.rs2 = 0; o.rd = 0; o.rw = 0; o.ld = 0;
    return o;
  endfunction

  function automatic bit m_lu();
    return pipe[0].v && pipe[0].ld && pipe[0].rd != 0 && hz.i_valid_d &&
           (pipe[0].rd == int'(hz.i_rs1_addr_d) || pipe[0].rd == int'(hz.i_rs2_addr_d));
  endfunction

  // Youngest producer after EX wins; stage 1 (MEM) -> 2, stage 2 (WB) -> 1.
  function automatic int m_fwd(input int src);
    if (!pipe[0].v) return 0;
    for (int s = 1; s <= 2; s++)
      if (pipe[s].v && pipe[s].rw && pipe[s].rd != 0 && pipe[s].rd == src)
        return (s == 1) ? 2 : 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 3; s++) pipe[s] = empty_occ();
      m_stall  = 0;
      m_flush  = 0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      bit lu, br;
      lu = m_lu();
      br = hz.i_pcsrc_e;
      if (lu && !br && m_stall < CMAX) m_stall++;
      if (br && m_flush < CMAX) m_flush++;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (lu || br) pipe[0] = empty_occ();
      else begin
        pipe[0].v   = hz.i_valid_d;
        pipe[0].rs1 = int'(hz.i_rs1_addr_d);
        pipe[0].rs2 = int'(hz.i_rs2_addr_d);
        pipe[0].rd  = int'(hz.i_rd_addr_d);
        pipe[0].rw  = hz.i_regwrite_d;
        pipe[0].ld  = (hz.i_resultsrc_d == 2'b01);
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok && !rst) begin
      bit lu, br;
      lu = m_lu();
      br = hz.i_pcsrc_e;
      check("m_stall_f",  32'(hz.o_stall_f),     32'(lu && !br));
      check("m_stall_d",  32'(hz.o_stall_d),     32'(lu && !br));
      check("m_flush_d",  32'(hz.o_flush_d),     32'(br));
      check("m_flush_e",  32'(hz.o_flush_e),     32'(lu || br));
      check("m_fwd_a",    32'(hz.o_forward_a_e), 32'(m_fwd(pipe[0].rs1)));
      check("m_fwd_b",    32'(hz.o_forward_b_e), 32'(m_fwd(pipe[0].rs2)));
      check("m_stall_cnt", 32'(hz.o_stall_cnt),  32'(m_stall));
      check("m_flush_cnt", 32'(hz.o_flush_cnt),  32'(m_flush));
    end
  end

  // ---------------- stimulus helpers
  task automatic set_d(input bit v, input int rs1, input int rs2, input int rd,
                       input bit rw, input logic [1:0] rsrc);
    hz.i_valid_d     = v;
    hz.i_rs1_addr_d  = AW'(rs1);
    hz.i_rs2_addr_d  = AW'(rs2);
    hz.i_rd_addr_d   = AW'(rd);
    hz.i_regwrite_d  = rw;
    hz.i_resultsrc_d = rsrc;
  endtask

  task automatic idle();
    set_d(0, 0, 0, 0, 0, 2'b00);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    hz.i_pcsrc_e = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    // Reset state
    check("rst_stall_f", 32'(hz.o_stall_f), 0);
    check("rst_flush_e", 32'(hz.o_flush_e), 0);
    check("rst_fwd_a",   32'(hz.o_forward_a_e), 0);
    check("rst_cnt",     32'(hz.o_stall_cnt), 0);

    // 1. Load-use: lw x5,0(x2) ; add x6,x5,x1
    set_d(1, 2, 0, 5, 1, 2'b01); #1;
    check("lu_no_stall_yet", 32'(hz.o_stall_f), 0);
    tick();
    set_d(1, 5, 1, 6, 1, 2'b00); #1;
    check("lu_stall_f", 32'(hz.o_stall_f), 1);
    check("lu_stall_d", 32'(hz.o_stall_d), 1);
    check("lu_flush_e", 32'(hz.o_flush_e), 1);
    tick(); #1;
    check("lu_stall_1cyc", 32'(hz.o_stall_d), 0);
    check("lu_stall_cnt",  32'(hz.o_stall_cnt), 1);
    tick(); idle(); #1;
    check("lu_fwd_a_wb", 32'(hz.o_forward_a_e), 1);
    check("lu_fwd_b_rf", 32'(hz.o_forward_b_e), 0);
    tick();

    // 2. addi x3 ; add x4,x3,x3 back-to-back, then with a spacer
    set_d(1, 0, 0, 3, 1, 2'b00); tick();
    set_d(1, 3, 3, 4, 1, 2'b00); #1;
    check("fwd_no_stall", 32'(hz.o_stall_d), 0);
    tick(); idle(); #1;
    check("fwd_mem_a", 32'(hz.o_forward_a_e), 2);
    check("fwd_mem_b", 32'(hz.o_forward_b_e), 2);
    set_d(1, 0, 0, 3, 1, 2'b00); tick();
    set_d(1, 0, 0, 9, 1, 2'b00); tick();
    set_d(1, 3, 3, 4, 1, 2'b00); tick(); idle(); #1;
    check("fwd_wb_a", 32'(hz.o_forward_a_e), 1);
    check("fwd_wb_b", 32'(hz.o_forward_b_e), 1);

    // 3. x0 never forwarded; MEM beats WB for x7
    set_d(1, 0, 0, 0, 1, 2'b00); tick();
    set_d(1, 0, 0, 1, 1, 2'b00); tick(); idle(); #1;
    check("x0_fwd_a", 32'(hz.o_forward_a_e), 0);
    check("x0_fwd_b", 32'(hz.o_forward_b_e), 0);
    set_d(1, 0, 0, 7, 1, 2'b00); tick();
    set_d(1, 0, 0, 7, 1, 2'b00); tick();
    set_d(1, 7, 0, 8, 1, 2'b00); tick(); idle(); #1;
    check("prio_fwd_a", 32'(hz.o_forward_a_e), 2);
    check("prio_fwd_b", 32'(hz.o_forward_b_e), 0);
    tick();

    // 4. Branch taken in the same cycle as a load-use hazard
    set_d(1, 2, 0, 5, 1, 2'b01); tick();
    set_d(1, 5, 1, 6, 1, 2'b00);
    hz.i_pcsrc_e = 1'b1; #1;
    check("br_flush_d", 32'(hz.o_flush_d), 1);
    check("br_flush_e", 32'(hz.o_flush_e), 1);
    check("br_stall_f", 32'(hz.o_stall_f), 0);
    check("br_stall_d", 32'(hz.o_stall_d), 0);
    tick();
    hz.i_pcsrc_e = 1'b0; idle(); #1;
    check("br_flush_cnt", 32'(hz.o_flush_cnt), 1);
    check("br_stall_cnt", 32'(hz.o_stall_cnt), 1);
    check("br_ex_bubble", 32'(hz.o_forward_a_e), 0);
    tick();

    // 5. Reset with a load in EX and writes in MEM/WB
    set_d(1, 0, 0, 7, 1, 2'b00); tick();
    set_d(1, 0, 0, 8, 1, 2'b00); tick();
    set_d(1, 2, 0, 5, 1, 2'b01); tick();
    set_d(1, 5, 7, 6, 1, 2'b00); #1;
    check("pre_rst_stall", 32'(hz.o_stall_d), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    check("post_rst_stall",  32'(hz.o_stall_d), 0);
    check("post_rst_flush",  32'(hz.o_flush_e), 0);
    check("post_rst_fwd_b",  32'(hz.o_forward_b_e), 0);
    check("post_rst_scnt",   32'(hz.o_stall_cnt), 0);
    check("post_rst_fcnt",   32'(hz.o_flush_cnt), 0);
    tick(); idle(); #1;
    check("post_rst_fwd_a",  32'(hz.o_forward_a_e), 0);
    tick();

    // 6. Nine load-use stalls saturate a 3-bit counter at 7
    for (int i = 0; i < 9; i++) begin
      set_d(1, 2, 0, 5, 1, 2'b01); tick();
      set_d(1, 5, 1, 6, 1, 2'b00); #1;
      check("sat_stall", 32'(hz.o_stall_d), 1);
      tick(); tick(); idle();
      if (i == 6) check("sat_reach7", 32'(hz.o_stall_cnt), 7);
      if (i == 5) check("sat_at6", 32'(hz.o_stall_cnt), 6);
    end
    #1;
    check("sat_hold7", 32'(hz.o_stall_cnt), 7);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
